// File: rtl/hazard_pkg.sv
// Shared types for the hazard sequencer: controller states, opcodes, forward selects.
// Used by pipeline_hazard_ctrl and fwd_unit.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_LD_STALL,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } ctrl_state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // The younger producer (EX) holds the newest value, so it wins.
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end
        if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Source-operand compare against the EX and MEM producers.
// Pure combinational: forward selects plus aggregate hit flags.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [2:0] i_reg1,
    input  logic [2:0] i_reg2,
    input  logic       i_use1,
    input  logic       i_use2,
    input  logic [2:0] i_ex_dest,
    input  logic       i_ex_wr,
    input  logic [2:0] i_mem_dest,
    input  logic       i_mem_wr,
    output fwd_sel_e   o_fwd_a,
    output fwd_sel_e   o_fwd_b,
    output logic       o_ex_hit,
    output logic       o_mem_hit
);

    logic w_ex_a;
    logic w_ex_b;
    logic w_mem_a;
    logic w_mem_b;

    assign w_ex_a  = i_ex_wr  & (i_ex_dest  == i_reg1) & i_use1;
    assign w_ex_b  = i_ex_wr  & (i_ex_dest  == i_reg2) & i_use2;
    assign w_mem_a = i_mem_wr & (i_mem_dest == i_reg1) & i_use1;
    assign w_mem_b = i_mem_wr & (i_mem_dest == i_reg2) & i_use2;

    assign o_fwd_a   = fwd_pick(w_ex_a, w_mem_a);
    assign o_fwd_b   = fwd_pick(w_ex_b, w_mem_b);
    assign o_ex_hit  = w_ex_a | w_ex_b;
    assign o_mem_hit = w_mem_a | w_mem_b;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward/halt sequencer for the 4-stage register chain of the 8-bit core.
// Macro FORWARDING_EN enables operand bypassing; without it every RAW hazard stalls.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       id_reg1,
    input  logic [2:0]       id_reg2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_is_halt,
    input  logic [3:0]       ex_opcode,
    input  logic [2:0]       ex_dest,
    input  logic             ex_writeReg,
    input  logic [2:0]       mem_dest,
    input  logic             mem_writeReg,
    input  logic [2:0]       wb_dest,
    input  logic             wb_writeReg,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    ctrl_state_e      r_state;
    ctrl_state_e      r_saved;
    logic [DW-1:0]    r_drain;
    logic [CNT_W-1:0] r_stall;

    ctrl_state_e w_eff;
    fwd_sel_e    w_fwd_a;
    fwd_sel_e    w_fwd_b;
    logic        w_ex_hit;
    logic        w_mem_hit;
    logic        w_halt_st;
    logic        w_data_stall;
    logic        w_drain_go;
    logic        w_unused_sink;

    fwd_unit u_fwd (
        .i_reg1     (id_reg1),
        .i_reg2     (id_reg2),
        .i_use1     (id_use1),
        .i_use2     (id_use2),
        .i_ex_dest  (ex_dest),
        .i_ex_wr    (ex_writeReg),
        .i_mem_dest (mem_dest),
        .i_mem_wr   (mem_writeReg),
        .o_fwd_a    (w_fwd_a),
        .o_fwd_b    (w_fwd_b),
        .o_ex_hit   (w_ex_hit),
        .o_mem_hit  (w_mem_hit)
    );

    // A memory wait is transparent: once it clears, act as the interrupted state.
    assign w_eff      = (r_state == ST_MEM_WAIT) ? r_saved : r_state;
    assign w_halt_st  = (r_state == ST_HALTED);
    assign w_drain_go = (w_eff == ST_DRAIN) | id_is_halt;

`ifdef FORWARDING_EN
    localparam ctrl_state_e STALL_NEXT = ST_LD_STALL;
    assign w_data_stall  = (w_eff == ST_RUN) & w_ex_hit & (ex_opcode == OP_LOAD);
    assign fwd_a_sel     = reset ? 2'b00 : 2'(w_fwd_a);
    assign fwd_b_sel     = reset ? 2'b00 : 2'(w_fwd_b);
    assign w_unused_sink = ^{wb_dest, wb_writeReg, w_mem_hit};
`else
    localparam ctrl_state_e STALL_NEXT = ST_RUN;
    assign w_data_stall  = (w_eff == ST_RUN) & (w_ex_hit | w_mem_hit);
    assign fwd_a_sel     = 2'b00;
    assign fwd_b_sel     = 2'b00;
    assign w_unused_sink = ^{wb_dest, wb_writeReg, ex_opcode, w_fwd_a, w_fwd_b};
`endif

    assign halted       = ~reset & w_halt_st;
    assign stall_cycles = reset ? '0 : r_stall;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_halt_st | mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_data_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (w_drain_go) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_saved <= ST_RUN;
            r_drain <= '0;
            r_stall <= '0;
        end else begin
            if (!pc_en && !w_halt_st && (r_stall != {CNT_W{1'b1}})) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            if (w_halt_st) begin
                if (resume) begin
                    r_state <= ST_RUN;
                end
            end else if (mem_busy) begin
                r_state <= ST_MEM_WAIT;
                r_saved <= w_eff;
            end else if (branch_taken) begin
                r_state <= ST_RUN;
                r_drain <= '0;
            end else if (w_data_stall) begin
                r_state <= STALL_NEXT;
            end else if (w_eff == ST_DRAIN) begin
                if (r_drain <= DW'(1)) begin
                    r_state <= ST_HALTED;
                    r_drain <= '0;
                end else begin
                    r_state <= ST_DRAIN;
                    r_drain <= r_drain - DW'(1);
                end
            end else if (id_is_halt) begin
                r_state <= ST_DRAIN;
                r_drain <= DW'(DRAIN_CYC);
            end else begin
                r_state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle reference model plus literal checks.
// Works with or without FORWARDING_EN defined.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [2:0]    id_reg1, id_reg2;
    logic          id_use1, id_use2, id_is_halt;
    logic [3:0]    ex_opcode;
    logic [2:0]    ex_dest, mem_dest, wb_dest;
    logic          ex_writeReg, mem_writeReg, wb_writeReg;
    logic          branch_taken, mem_busy, resume;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, halted;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cycles;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: memory wait is a pure freeze; drain is a countdown of remaining cycles.
    bit m_halted   = 1'b0;
    bit m_after_ld = 1'b0;
    int m_drain    = 0;
    int m_sc       = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_reg1(id_reg1), .id_reg2(id_reg2),
        .id_use1(id_use1), .id_use2(id_use2),
        .id_is_halt(id_is_halt),
        .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_writeReg(ex_writeReg),
        .mem_dest(mem_dest), .mem_writeReg(mem_writeReg),
        .wb_dest(wb_dest), .wb_writeReg(wb_writeReg),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    function automatic bit hit(input logic [2:0] d, input logic w);
        return w && ((id_use1 && d == id_reg1) || (id_use2 && d == id_reg2));
    endfunction

    function automatic bit data_hazard();
        bit h;
        if (FWD) h = hit(ex_dest, ex_writeReg) && (ex_opcode == 4'h4);
        else     h = hit(ex_dest, ex_writeReg) || hit(mem_dest, mem_writeReg);
        return h && !m_after_ld;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [2:0] r, input logic u);
        logic [1:0] s;
        s = 2'd0;
        if (u && mem_writeReg && mem_dest == r) s = 2'd2;
        if (u && ex_writeReg && ex_dest == r) s = 2'd1;
        if (!FWD || reset) s = 2'd0;
        return s;
    endfunction

    function automatic logic [15:0] expect_out();
        logic [4:0] en;
        logic [1:0] fl;
        logic       h;
        logic [3:0] sc;
        en = 5'b11111;
        fl = 2'b00;
        h  = 1'b0;
        sc = m_sc[3:0];
        if (reset) begin
            en = 5'b0; fl = 2'b11; sc = 4'd0;
        end else if (m_halted) begin
            en = 5'b0; h = 1'b1;
        end else if (mem_busy) begin
            en = 5'b0;
        end else if (branch_taken) begin
            fl = 2'b11;
        end else if (m_drain > 0) begin
            en[4] = 1'b0; fl = 2'b10;
        end else if (data_hazard()) begin
            en[4:3] = 2'b00; fl = 2'b01;
        end else if (id_is_halt) begin
            en[4] = 1'b0; fl = 2'b10;
        end
        return {en, fl, exp_fwd(id_reg1, id_use1), exp_fwd(id_reg2, id_use2), h, sc};
    endfunction

    always @(posedge clk) begin
        logic [15:0] e;
        e = expect_out();
        if (reset) begin
            m_halted = 1'b0; m_after_ld = 1'b0; m_drain = 0; m_sc = 0;
        end else begin
            if (!e[15] && !m_halted && m_sc < SAT) m_sc++;
            if (m_halted) begin
                if (resume) m_halted = 1'b0;
            end else if (mem_busy) begin
                m_sc = m_sc;
            end else if (branch_taken) begin
                m_drain = 0; m_after_ld = 1'b0;
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_halted = 1'b1;
            end else if (data_hazard()) begin
                m_after_ld = FWD;
            end else begin
                m_after_ld = 1'b0;
                if (id_is_halt) m_drain = 3;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e, a;
        e = expect_out();
        a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             fwd_a_sel, fwd_b_sel, halted, stall_cycles};
        n_vec++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL model t=%0t got %h want %h", $time, a, e);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        reset = 1'b0; id_reg1 = 3'd0; id_reg2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        id_is_halt = 1'b0; ex_opcode = OP_NOP; ex_dest = 3'd0; ex_writeReg = 1'b0;
        mem_dest = 3'd0; mem_writeReg = 1'b0; wb_dest = 3'd0; wb_writeReg = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0; resume = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        clr();
        reset = 1'b1;
        settle();
        chk("rst_pc", int'(pc_en), 0);
        chk("rst_ifid_fl", int'(ifid_flush), 1);
        chk("rst_idex_fl", int'(idex_flush), 1);
        chk("rst_sc", int'(stall_cycles), 0);
        chk("rst_halted", int'(halted), 0);
        adv();

        // LW r3 in EX, consumer of r3 in ID
        ex_opcode = OP_LOAD; ex_dest = 3'd3; ex_writeReg = 1'b1;
        id_reg1 = 3'd3; id_use1 = 1'b1;
        settle();
        chk("lu_pc", int'(pc_en), 0);
        chk("lu_ifid_en", int'(ifid_en), 0);
        chk("lu_idex_fl", int'(idex_flush), 1);
        adv();
        mem_dest = 3'd3; mem_writeReg = 1'b1; id_reg1 = 3'd3; id_use1 = 1'b1;
        settle();
        chk("lu_next_pc", int'(pc_en), FWD ? 1 : 0);
        chk("lu_fwd_a", int'(fwd_a_sel), FWD ? 2 : 0);
        adv();
        wb_dest = 3'd3; wb_writeReg = 1'b1; id_reg1 = 3'd3; id_use1 = 1'b1;
        settle();
        chk("lu_wb_pc", int'(pc_en), 1);
        chk("lu_sc", int'(stall_cycles), FWD ? 1 : 2);
        adv();

        // ADD r2 then SUB r4,r2
        ex_opcode = 4'h1; ex_dest = 3'd2; ex_writeReg = 1'b1;
        id_reg1 = 3'd2; id_use1 = 1'b1; id_reg2 = 3'd4; id_use2 = 1'b1;
        settle();
        chk("alu_pc", int'(pc_en), FWD ? 1 : 0);
        chk("alu_fwd_a", int'(fwd_a_sel), FWD ? 1 : 0);
        adv();
        mem_dest = 3'd2; mem_writeReg = 1'b1;
        id_reg1 = 3'd2; id_use1 = 1'b1; id_reg2 = 3'd4; id_use2 = 1'b1;
        settle();
        chk("alu_mem_pc", int'(pc_en), FWD ? 1 : 0);
        chk("alu_mem_fwd_a", int'(fwd_a_sel), FWD ? 2 : 0);
        adv();
        settle();
        chk("alu_sc", int'(stall_cycles), FWD ? 1 : 4);
        adv();

        // branch and load-use in the same cycle
        ex_opcode = OP_LOAD; ex_dest = 3'd5; ex_writeReg = 1'b1;
        id_reg2 = 3'd5; id_use2 = 1'b1; branch_taken = 1'b1;
        settle();
        chk("br_pc", int'(pc_en), 1);
        chk("br_ifid_fl", int'(ifid_flush), 1);
        chk("br_idex_fl", int'(idex_flush), 1);
        adv();
        settle();
        chk("br_next_pc", int'(pc_en), 1);
        chk("br_sc", int'(stall_cycles), FWD ? 1 : 4);
        adv();

        // HALT cancelled by branch on 2nd drain cycle
        id_is_halt = 1'b1;
        settle();
        chk("hb_pc", int'(pc_en), 0);
        chk("hb_ifid_fl", int'(ifid_flush), 1);
        adv();
        settle();
        chk("hb_drain_pc", int'(pc_en), 0);
        adv();
        branch_taken = 1'b1;
        settle();
        chk("hb_br_pc", int'(pc_en), 1);
        adv();
        settle();
        chk("hb_halted", int'(halted), 0);
        chk("hb_sc", int'(stall_cycles), FWD ? 3 : 6);
        adv();

        // HALT with a 4-cycle memory wait inside the drain
        id_is_halt = 1'b1;
        settle();
        adv();
        settle();
        adv();
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1'b1;
            settle();
            chk("hw_busy_fl", int'(ifid_flush), 0);
            adv();
        end
        settle();
        adv();
        settle();
        chk("hw_pre_halt", int'(halted), 0);
        adv();
        settle();
        chk("hw_halted", int'(halted), 1);
        chk("hw_sc", int'(stall_cycles), FWD ? 11 : 14);
        adv();
        resume = 1'b1;
        settle();
        chk("hw_res_pc", int'(pc_en), 0);
        adv();
        settle();
        chk("hw_run_pc", int'(pc_en), 1);
        chk("hw_run_halted", int'(halted), 0);
        adv();

        // EX beats MEM on the same source; unused source never hazards
        ex_opcode = 4'h1; ex_dest = 3'd6; ex_writeReg = 1'b1;
        mem_dest = 3'd6; mem_writeReg = 1'b1; id_reg2 = 3'd6; id_use2 = 1'b1;
        settle();
        chk("pri_fwd_b", int'(fwd_b_sel), FWD ? 1 : 0);
        chk("pri_pc", int'(pc_en), FWD ? 1 : 0);
        adv();
        ex_opcode = OP_LOAD; ex_dest = 3'd6; ex_writeReg = 1'b1;
        id_reg1 = 3'd6; id_use1 = 1'b0;
        settle();
        chk("nouse_pc", int'(pc_en), 1);
        adv();

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            mem_busy = 1'b1;
            settle();
            adv();
        end
        settle();
        chk("sat_sc", int'(stall_cycles), SAT);
        adv();

        // reset while draining
        id_is_halt = 1'b1;
        settle();
        adv();
        settle();
        adv();
        reset = 1'b1;
        settle();
        chk("rd_ifid_fl", int'(ifid_flush), 1);
        chk("rd_idex_fl", int'(idex_flush), 1);
        chk("rd_sc", int'(stall_cycles), 0);
        adv();
        settle();
        chk("rd_pc", int'(pc_en), 1);
        chk("rd_halted", int'(halted), 0);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
